// File: rtl/ysyx_23060184_lsu_axi_if.sv
// ysyx_23060184_lsu_axi_if: AXI4-Lite read/write channel bundle between the LSU and the interconnect
interface ysyx_23060184_lsu_axi_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_23060184_lsu_axi.sv
// ysyx_23060184_lsu_axi: load/store unit turning each EX memory op into one arbitrated AXI4-Lite transaction
module ysyx_23060184_lsu_axi #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGIONS = 2,
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = {32'h0f00_0000, 32'h1000_0000},
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK = {32'hff00_0000, 32'hffff_f000},
    parameter int GRANT_WIDTH = 2,
    parameter logic [GRANT_WIDTH-1:0] GRANT_ID = 2'b10
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   ex_valid,
    output logic                   lsu_ready,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [1:0]             size,
    input  logic                   is_unsigned,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  st_data,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [DATA_WIDTH-1:0]  ld_result,
    output logic                   fault,
    output logic [1:0]             fault_cause,
    output logic                   arb_req,
    input  logic [GRANT_WIDTH-1:0] arb_grant,
    output logic [NUM_REGIONS-1:0] region_sel,
    ysyx_23060184_lsu_axi_if.master axi
);
    localparam int STRB = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(STRB);

    typedef enum logic [2:0] {IDLE, REQ, AR, R, AW_W, B, DONE} state_t;

    state_t                  state;
    logic [OFFW-1:0]         off_q;
    logic [1:0]              size_q;
    logic                    uns_q;
    logic                    load_q;

    logic                    is_mem;
    logic                    mis;
    logic                    unmapped;
    logic [NUM_REGIONS-1:0]  hit;
    logic [OFFW-1:0]         off;
    logic [ADDR_WIDTH-1:0]   aligned;
    logic [STRB-1:0]         lanes;
    logic [DATA_WIDTH-1:0]   sh;
    logic [DATA_WIDTH-1:0]   keep;
    logic                    neg;
    logic [DATA_WIDTH-1:0]   ld_ext;
    logic                    aw_ok;
    logic                    w_ok;

    // Lowest-indexed region wins, so scan downwards and let lower hits overwrite.
    always_comb begin
        hit = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--)
            if ((addr & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])
                hit = NUM_REGIONS'(1) << i;
    end

    always_comb begin
        is_mem   = mem_read || mem_write;
        off      = addr[OFFW-1:0];
        aligned  = {addr[ADDR_WIDTH-1:OFFW], OFFW'(0)};
        unmapped = hit == '0;
        mis      = size == 2'd1 ? addr[0] :
                   size == 2'd2 ? |addr[1:0] :
                   size == 2'd3 ? (DATA_WIDTH == 32 || |addr[2:0]) : 1'b0;
        lanes    = size == 2'd0 ? STRB'(1) : size == 2'd1 ? STRB'(3) : size == 2'd2 ? STRB'(15) : '1;
        sh       = axi.rdata >> {off_q, 3'b000};
        keep     = size_q == 2'd0 ? DATA_WIDTH'(64'hff) :
                   size_q == 2'd1 ? DATA_WIDTH'(64'hffff) :
                   size_q == 2'd2 ? DATA_WIDTH'(64'hffff_ffff) : '1;
        neg      = !uns_q && (size_q == 2'd0 ? sh[7] : size_q == 2'd1 ? sh[15] : size_q == 2'd2 ? sh[31] : 1'b0);
        ld_ext   = (sh & keep) | (neg ? ~keep : '0);
        aw_ok    = !axi.awvalid || axi.awready;
        w_ok     = !axi.wvalid || axi.wready;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            lsu_ready   <= 1'b1;
            wb_valid    <= 1'b0;
            ld_result   <= '0;
            fault       <= 1'b0;
            fault_cause <= 2'd0;
            arb_req     <= 1'b0;
            region_sel  <= '0;
            off_q       <= '0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            load_q      <= 1'b0;
            axi.araddr  <= '0;
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b0;
            axi.awaddr  <= '0;
            axi.awvalid <= 1'b0;
            axi.wdata   <= '0;
            axi.wstrb   <= '0;
            axi.wvalid  <= 1'b0;
            axi.bready  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ex_valid) begin
                    lsu_ready  <= 1'b0;
                    off_q      <= off;
                    size_q     <= size;
                    uns_q      <= is_unsigned;
                    load_q     <= mem_read;
                    region_sel <= is_mem ? hit : '0;
                    ld_result  <= '0;
                    if (!is_mem || mis || unmapped) begin
                        state       <= DONE;
                        wb_valid    <= 1'b1;
                        fault       <= is_mem;
                        fault_cause <= is_mem && !mis ? 2'd1 : 2'd0;
                    end else begin
                        state       <= REQ;
                        arb_req     <= 1'b1;
                        fault       <= 1'b0;
                        fault_cause <= 2'd0;
                        if (mem_read) axi.araddr <= aligned;
                        else begin
                            axi.awaddr <= aligned;
                            axi.wdata  <= st_data << {off, 3'b000};
                            axi.wstrb  <= lanes << off;
                        end
                    end
                end
                REQ: if (arb_grant == GRANT_ID) begin
                    state       <= load_q ? AR : AW_W;
                    axi.arvalid <= load_q;
                    axi.awvalid <= !load_q;
                    axi.wvalid  <= !load_q;
                end
                AR: if (axi.arready) begin
                    state       <= R;
                    axi.arvalid <= 1'b0;
                    axi.rready  <= 1'b1;
                end
                R: if (axi.rvalid) begin
                    state       <= DONE;
                    axi.rready  <= 1'b0;
                    wb_valid    <= 1'b1;
                    fault       <= |axi.rresp;
                    fault_cause <= |axi.rresp ? 2'd2 : 2'd0;
                    ld_result   <= |axi.rresp ? '0 : ld_ext;
                end
                // Address and data channels complete independently, in any order.
                AW_W: begin
                    if (axi.awready) axi.awvalid <= 1'b0;
                    if (axi.wready) axi.wvalid <= 1'b0;
                    if (aw_ok && w_ok) begin
                        state      <= B;
                        axi.bready <= 1'b1;
                    end
                end
                B: if (axi.bvalid) begin
                    state       <= DONE;
                    axi.bready  <= 1'b0;
                    wb_valid    <= 1'b1;
                    fault       <= |axi.bresp;
                    fault_cause <= |axi.bresp ? 2'd2 : 2'd0;
                end
                DONE: if (wb_ready) begin
                    state       <= IDLE;
                    lsu_ready   <= 1'b1;
                    wb_valid    <= 1'b0;
                    arb_req     <= 1'b0;
                    region_sel  <= '0;
                    fault       <= 1'b0;
                    fault_cause <= 2'd0;
                    ld_result   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060184_lsu_axi.sv
// tb_ysyx_23060184_lsu_axi: directed checks of the LSU on 32-bit and 64-bit instances
module tb_ysyx_23060184_lsu_axi;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        ex_valid, ex_valid64, mem_read, mem_write, is_unsigned, wb_ready;
    logic [1:0]  size, arb_grant;
    logic [31:0] addr, st_data;
    logic [63:0] st_data64;
    logic        lsu_ready, wb_valid, fault, arb_req;
    logic [31:0] ld_result;
    logic [1:0]  fault_cause, region_sel;
    logic        lsu_ready64, wb_valid64, fault64, arb_req64;
    logic [63:0] ld_result64;
    logic [1:0]  fault_cause64, region_sel64;

    int vectors = 0;
    int errs = 0;

    ysyx_23060184_lsu_axi_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
    ysyx_23060184_lsu_axi_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus64 ();

    ysyx_23060184_lsu_axi #(.DATA_WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .lsu_ready(lsu_ready),
        .mem_read(mem_read), .mem_write(mem_write), .size(size), .is_unsigned(is_unsigned),
        .addr(addr), .st_data(st_data), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .ld_result(ld_result), .fault(fault), .fault_cause(fault_cause), .arb_req(arb_req),
        .arb_grant(arb_grant), .region_sel(region_sel), .axi(bus)
    );

    ysyx_23060184_lsu_axi #(.DATA_WIDTH(64)) dut64 (
        .clk(clk), .resetn(resetn), .ex_valid(ex_valid64), .lsu_ready(lsu_ready64),
        .mem_read(mem_read), .mem_write(mem_write), .size(size), .is_unsigned(is_unsigned),
        .addr(addr), .st_data(st_data64), .wb_valid(wb_valid64), .wb_ready(wb_ready),
        .ld_result(ld_result64), .fault(fault64), .fault_cause(fault_cause64), .arb_req(arb_req64),
        .arb_grant(arb_grant), .region_sel(region_sel64), .axi(bus64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] sd);
        mem_read = rd; mem_write = wr; size = sz; is_unsigned = uns; addr = a; st_data = sd;
        ex_valid = 1'b1;
        chk("accept lsu_ready", lsu_ready, 1'b1);
        tick;
        ex_valid = 1'b0;
    endtask

    task automatic load_run(input string tag, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                            input logic [31:0] rd, input logic [1:0] resp, input int gdly, input int hold,
                            input logic [31:0] exp_araddr, input logic [31:0] exp_res, input logic [1:0] exp_sel);
        arb_grant = gdly > 0 ? 2'b01 : 2'b10;
        issue(1'b1, 1'b0, sz, uns, a, 32'h0);
        for (int i = 0; i < gdly; i++) begin
            chk({tag, " grant-wait arvalid"}, bus.arvalid, 1'b0);
            chk({tag, " grant-wait arb_req"}, arb_req, 1'b1);
            tick;
        end
        arb_grant = 2'b10;
        chk({tag, " req arb_req"}, arb_req, 1'b1);
        chk({tag, " region_sel"}, region_sel, exp_sel);
        chk({tag, " req arvalid"}, bus.arvalid, 1'b0);
        tick;
        chk({tag, " ar arvalid"}, bus.arvalid, 1'b1);
        chk({tag, " araddr"}, bus.araddr, exp_araddr);
        tick;
        chk({tag, " r rready"}, bus.rready, 1'b1);
        chk({tag, " r arvalid"}, bus.arvalid, 1'b0);
        chk({tag, " r wb_valid"}, wb_valid, 1'b0);
        bus.rvalid = 1'b1; bus.rdata = rd; bus.rresp = resp;
        tick;
        bus.rvalid = 1'b0; bus.rresp = 2'b00;
        chk({tag, " wb_valid"}, wb_valid, 1'b1);
        chk({tag, " ld_result"}, ld_result, exp_res);
        chk({tag, " fault"}, fault, resp != 2'b00);
        if (resp != 2'b00) chk({tag, " fault_cause"}, fault_cause, 2'd2);
        chk({tag, " done lsu_ready"}, lsu_ready, 1'b0);
        if (hold > 0) begin
            wb_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                tick;
                chk({tag, " stall wb_valid"}, wb_valid, 1'b1);
                chk({tag, " stall ld_result"}, ld_result, exp_res);
                chk({tag, " stall fault"}, fault, resp != 2'b00);
                chk({tag, " stall lsu_ready"}, lsu_ready, 1'b0);
            end
            wb_ready = 1'b1;
        end
        tick;
        chk({tag, " idle wb_valid"}, wb_valid, 1'b0);
        chk({tag, " idle lsu_ready"}, lsu_ready, 1'b1);
        chk({tag, " idle region_sel"}, region_sel, 2'b00);
    endtask

    task automatic store_run(input string tag, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] sd,
                             input int wdly, input logic [1:0] resp, input logic [31:0] exp_awaddr,
                             input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb, input logic [1:0] exp_sel);
        bus.wready = wdly == 0;
        issue(1'b0, 1'b1, sz, 1'b0, a, sd);
        chk({tag, " req arb_req"}, arb_req, 1'b1);
        chk({tag, " region_sel"}, region_sel, exp_sel);
        chk({tag, " req awvalid"}, bus.awvalid, 1'b0);
        tick;
        chk({tag, " awvalid"}, bus.awvalid, 1'b1);
        chk({tag, " wvalid"}, bus.wvalid, 1'b1);
        chk({tag, " awaddr"}, bus.awaddr, exp_awaddr);
        chk({tag, " wdata"}, bus.wdata, exp_wdata);
        chk({tag, " wstrb"}, bus.wstrb, exp_wstrb);
        for (int i = 0; i < wdly; i++) begin
            tick;
            chk({tag, " w-wait awvalid"}, bus.awvalid, 1'b0);
            chk({tag, " w-wait wvalid"}, bus.wvalid, 1'b1);
            chk({tag, " w-wait bready"}, bus.bready, 1'b0);
            if (i == wdly - 1) bus.wready = 1'b1;
        end
        tick;
        chk({tag, " b bready"}, bus.bready, 1'b1);
        chk({tag, " b wvalid"}, bus.wvalid, 1'b0);
        chk({tag, " b wb_valid"}, wb_valid, 1'b0);
        bus.bvalid = 1'b1; bus.bresp = resp;
        tick;
        bus.bvalid = 1'b0; bus.bresp = 2'b00;
        chk({tag, " wb_valid"}, wb_valid, 1'b1);
        chk({tag, " fault"}, fault, resp != 2'b00);
        if (resp != 2'b00) chk({tag, " fault_cause"}, fault_cause, 2'd2);
        chk({tag, " ld_result"}, ld_result, 32'h0);
        tick;
        chk({tag, " idle wb_valid"}, wb_valid, 1'b0);
        chk({tag, " idle lsu_ready"}, lsu_ready, 1'b1);
    endtask

    task automatic fault_run(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                             input logic [31:0] a, input logic exp_fault, input logic [1:0] exp_cause);
        issue(rd, wr, sz, 1'b0, a, 32'hffff_ffff);
        chk({tag, " wb_valid"}, wb_valid, 1'b1);
        chk({tag, " fault"}, fault, exp_fault);
        if (exp_fault) chk({tag, " fault_cause"}, fault_cause, exp_cause);
        chk({tag, " ld_result"}, ld_result, 32'h0);
        chk({tag, " arb_req"}, arb_req, 1'b0);
        chk({tag, " arvalid"}, bus.arvalid, 1'b0);
        chk({tag, " awvalid"}, bus.awvalid, 1'b0);
        tick;
        chk({tag, " idle wb_valid"}, wb_valid, 1'b0);
        chk({tag, " idle arvalid"}, bus.arvalid, 1'b0);
        chk({tag, " idle lsu_ready"}, lsu_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; ex_valid = 1'b0; ex_valid64 = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        size = 2'd0; is_unsigned = 1'b0; addr = 32'h0; st_data = 32'h0; st_data64 = 64'h0;
        wb_ready = 1'b1; arb_grant = 2'b10;
        bus.arready = 1'b1; bus.rdata = '0; bus.rresp = 2'b00; bus.rvalid = 1'b0;
        bus.awready = 1'b1; bus.wready = 1'b1; bus.bresp = 2'b00; bus.bvalid = 1'b0;
        bus64.arready = 1'b1; bus64.rdata = '0; bus64.rresp = 2'b00; bus64.rvalid = 1'b0;
        bus64.awready = 1'b1; bus64.wready = 1'b1; bus64.bresp = 2'b00; bus64.bvalid = 1'b0;
        tick;
        tick;
        chk("reset lsu_ready", lsu_ready, 1'b1);
        chk("reset wb_valid", wb_valid, 1'b0);
        chk("reset arb_req", arb_req, 1'b0);
        chk("reset fault", fault, 1'b0);
        chk("reset fault_cause", fault_cause, 2'd0);
        chk("reset ld_result", ld_result, 32'h0);
        chk("reset region_sel", region_sel, 2'b00);
        chk("reset arvalid", bus.arvalid, 1'b0);
        chk("reset awvalid", bus.awvalid, 1'b0);
        chk("reset wvalid", bus.wvalid, 1'b0);
        chk("reset araddr", bus.araddr, 32'h0);
        chk("reset wstrb", bus.wstrb, 4'h0);
        chk("reset wdata", bus.wdata, 32'h0);
        chk("reset lsu_ready64", lsu_ready64, 1'b1);
        resetn = 1'b1;
        tick;

        load_run("lw",        2'd2, 1'b0, 32'h0f00_0004, 32'hdead_beef, 2'b00, 0, 0, 32'h0f00_0004, 32'hdead_beef, 2'b10);
        load_run("lb",        2'd0, 1'b0, 32'h0f00_0003, 32'h8000_0000, 2'b00, 0, 0, 32'h0f00_0000, 32'hffff_ff80, 2'b10);
        load_run("lbu",       2'd0, 1'b1, 32'h0f00_0003, 32'h8000_0000, 2'b00, 0, 0, 32'h0f00_0000, 32'h0000_0080, 2'b10);
        load_run("lh grant2", 2'd1, 1'b0, 32'h1000_0002, 32'h8765_4321, 2'b00, 2, 0, 32'h1000_0000, 32'hffff_8765, 2'b01);
        load_run("lhu",       2'd1, 1'b1, 32'h0f00_0000, 32'h8765_4321, 2'b00, 0, 0, 32'h0f00_0000, 32'h0000_4321, 2'b10);
        load_run("lw rerr",   2'd2, 1'b0, 32'h1000_0010, 32'h1234_5678, 2'b10, 0, 5, 32'h1000_0010, 32'h0000_0000, 2'b01);

        store_run("sh slow-w", 2'd1, 32'h1000_0002, 32'h0000_1234, 3, 2'b00, 32'h1000_0000, 32'h1234_0000, 4'b1100, 2'b01);
        store_run("sw",        2'd2, 32'h1000_0ffc, 32'hcafe_f00d, 0, 2'b00, 32'h1000_0ffc, 32'hcafe_f00d, 4'b1111, 2'b01);
        store_run("sb berr",   2'd0, 32'h0f00_0001, 32'h0000_00ab, 0, 2'b11, 32'h0f00_0000, 32'h0000_ab00, 4'b0010, 2'b10);

        fault_run("lw misaligned", 1'b1, 1'b0, 2'd2, 32'h0f00_0002, 1'b1, 2'd0);
        fault_run("lw unmapped",   1'b1, 1'b0, 2'd2, 32'h2000_0000, 1'b1, 2'd1);
        fault_run("lw past 4k",    1'b1, 1'b0, 2'd2, 32'h1000_1000, 1'b1, 2'd1);
        fault_run("sh misaligned", 1'b0, 1'b1, 2'd1, 32'h0f00_0001, 1'b1, 2'd0);
        fault_run("ld on 32-bit",  1'b1, 1'b0, 2'd3, 32'h0f00_0000, 1'b1, 2'd0);
        fault_run("pass-through",  1'b0, 1'b0, 2'd2, 32'h2000_0001, 1'b0, 2'd0);

        mem_read = 1'b0; mem_write = 1'b1; size = 2'd3; is_unsigned = 1'b0; addr = 32'h0f00_0008;
        st_data64 = 64'h1122_3344_5566_7788; ex_valid64 = 1'b1;
        chk("sd64 lsu_ready", lsu_ready64, 1'b1);
        tick;
        ex_valid64 = 1'b0;
        chk("sd64 arb_req", arb_req64, 1'b1);
        chk("sd64 region_sel", region_sel64, 2'b10);
        tick;
        chk("sd64 awvalid", bus64.awvalid, 1'b1);
        chk("sd64 wvalid", bus64.wvalid, 1'b1);
        chk("sd64 awaddr", bus64.awaddr, 32'h0f00_0008);
        chk("sd64 wdata", bus64.wdata, 64'h1122_3344_5566_7788);
        chk("sd64 wstrb", bus64.wstrb, 8'hff);
        tick;
        chk("sd64 bready", bus64.bready, 1'b1);
        bus64.bvalid = 1'b1;
        tick;
        bus64.bvalid = 1'b0;
        chk("sd64 wb_valid", wb_valid64, 1'b1);
        chk("sd64 fault", fault64, 1'b0);
        tick;
        chk("sd64 idle lsu_ready", lsu_ready64, 1'b1);

        mem_read = 1'b1; mem_write = 1'b0; size = 2'd2; addr = 32'h0f00_0004; ex_valid64 = 1'b1;
        tick;
        ex_valid64 = 1'b0;
        tick;
        chk("lw64 arvalid", bus64.arvalid, 1'b1);
        chk("lw64 araddr", bus64.araddr, 32'h0f00_0000);
        tick;
        chk("lw64 rready", bus64.rready, 1'b1);
        bus64.rvalid = 1'b1; bus64.rdata = 64'h89ab_cdef_0123_4567;
        tick;
        bus64.rvalid = 1'b0;
        chk("lw64 wb_valid", wb_valid64, 1'b1);
        chk("lw64 ld_result", ld_result64, 64'hffff_ffff_89ab_cdef);
        tick;

        mem_read = 1'b1; mem_write = 1'b0; size = 2'd3; addr = 32'h0f00_0004; ex_valid64 = 1'b1;
        tick;
        ex_valid64 = 1'b0;
        chk("ld64 misaligned wb_valid", wb_valid64, 1'b1);
        chk("ld64 misaligned fault", fault64, 1'b1);
        chk("ld64 misaligned cause", fault_cause64, 2'd0);
        chk("ld64 misaligned arvalid", bus64.arvalid, 1'b0);
        tick;
        chk("ld64 idle lsu_ready", lsu_ready64, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
